// File: rtl/key_event_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes and produces held flags and
// press pulses for the shift and gas keys; typematic repeats do not pulse.
module key_event_decoder #(
  parameter logic [7:0]  SHIFT_CODE  = 8'h29,
  parameter logic        SHIFT_EXT   = 1'b0,
  parameter logic [7:0]  GAS_CODE    = 8'h75,
  parameter logic        GAS_EXT     = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 650000,
  parameter int unsigned TO_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_status,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       shift_posedge,
  output logic       shift_held,
  output logic       gas_posedge,
  output logic       gas_held
);

  localparam logic [7:0]      CODE_EXT = 8'hE0;
  localparam logic [7:0]      CODE_BRK = 8'hF0;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;

  logic is_e0;
  logic is_f0;
  logic ev_valid;
  logic ev_ext;
  logic ev_break;
  logic shift_hit;
  logic gas_hit;

  // Decode the event a non-prefix byte completes in the current state
  always_comb begin
    is_e0     = (rx_data == CODE_EXT);
    is_f0     = (rx_data == CODE_BRK);
    ev_valid  = rx_valid && !is_e0 && !is_f0;
    ev_ext    = (state == EXT) || (state == EXT_BRK);
    ev_break  = (state == BRK) || (state == EXT_BRK);
    shift_hit = ev_valid && (rx_data == SHIFT_CODE) && (ev_ext == SHIFT_EXT);
    gas_hit   = ev_valid && (rx_data == GAS_CODE) && (ev_ext == GAS_EXT);
  end

  always_ff @(posedge clk) begin
    if (rst || reset_status) begin
      state         <= IDLE;
      to_cnt        <= '0;
      shift_posedge <= 1'b0;
      shift_held    <= 1'b0;
      gas_posedge   <= 1'b0;
      gas_held      <= 1'b0;
    end else begin
      shift_posedge <= 1'b0;
      gas_posedge   <= 1'b0;

      if (rx_valid) begin
        to_cnt <= '0;
        unique case (state)
          IDLE:    state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
          EXT:     state <= is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
          BRK:     state <= is_e0 ? EXT_BRK : (is_f0 ? BRK : IDLE);
          EXT_BRK: state <= (is_e0 || is_f0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // Abandon a partial prefix sequence after a long silence
        if (to_cnt == TO_LAST) begin
          state  <= IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end

      if (shift_hit) begin
        if (ev_break) begin
          shift_held <= 1'b0;
        end else begin
          shift_held    <= 1'b1;
          shift_posedge <= !shift_held;
        end
      end

      if (gas_hit) begin
        if (ev_break) begin
          gas_held <= 1'b0;
        end else begin
          gas_held    <= 1'b1;
          gas_posedge <= !gas_held;
        end
      end
    end
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Converts the PS/2 scan-code byte stream into key-level events for the game logic. It tracks make, break and extended prefixes (E0, F0), and keeps a held flag for two configured keys: shift and gas. It emits a one-cycle press pulse only on a real press, so typematic repeats produce no pulse. It sits between the PS/2 byte receiver and the gear shifter / throttle logic, and is the producer of the shifter's keyboard posedge input.

Parameters:
SHIFT_CODE, 8'h29, scan code of the shift key (space)
SHIFT_EXT, 1'b0, 1 = shift key is an E0-prefixed code
GAS_CODE, 8'h75, scan code of the gas key (up arrow)
GAS_EXT, 1'b1, 1 = gas key is an E0-prefixed code
TIMEOUT_CYC, 650000, idle cycles after which a partial prefix sequence is discarded (10 ms at 65 MHz)
TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
reset_status  in  1  synchronous game-restart clear; same effect as rst
rx_data  in  8  received scan-code byte
rx_valid  in  1  one-cycle strobe; every cycle it is high consumes one byte
shift_posedge  out  1  one-cycle pulse on a shift key press
shift_held  out  1  shift key currently down
gas_posedge  out  1  one-cycle pulse on a gas key press
gas_held  out  1  gas key currently down

Behaviour:
- Reset (rst or reset_status high at a clk edge):
  - FSM goes to IDLE and the timeout counter clears.
  - All four outputs are 0 in the following cycle.
  - Reset overrides any byte presented in the same cycle.
- All outputs are registered. A press pulse asserts in the cycle after the rx_valid cycle of the final byte of the sequence, and lasts exactly 1 cycle.
- FSM states and transitions (taken only when rx_valid=1):
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(byte, ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> make(byte, ext=1), go IDLE.
  - BRK: E0 -> EXT_BRK; F0 -> stay BRK; other byte -> break(byte, ext=0), go IDLE.
  - EXT_BRK: E0 or F0 -> stay EXT_BRK; other byte -> break(byte, ext=1), go IDLE.
- Key matching: a key matches only when both code and ext equal the key's parameters. For example, 75 without E0 does not match GAS with GAS_EXT=1.
- make on a matching key:
  - held=0: held goes to 1 and posedge pulses.
  - held=1 (typematic repeat): no pulse, held stays 1.
- break on a matching key: held goes to 0, no pulse. A break for a key that is not held has no effect.
- Non-matching codes, including AA, FA, FE and EE, change no outputs; the FSM still follows the table above.
- Timeout:
  - In EXT, BRK or EXT_BRK the counter increments on every cycle with rx_valid=0.
  - When it reaches TIMEOUT_CYC-1, the FSM returns to IDLE and the counter clears. No event is generated.
  - The counter clears on every rx_valid and whenever the FSM is in IDLE.
- Keys are independent: shift held and gas held may both be 1. At most one event can occur per cycle, since only one byte arrives per cycle.
- Pulses never coincide with reset. reset_status during a held key clears held, and the next make then produces a fresh pulse.

Test Plan:
- After rst, byte 29 -> shift_posedge=1 for exactly 1 cycle, the cycle after rx_valid; shift_held=1 from then on; gas outputs stay 0.
- Bytes 29,29,29 (typematic), then F0,29 -> a single shift_posedge pulse; shift_held falls to 0 the cycle after the final 29.
- Bytes E0,75 -> gas_posedge pulse and gas_held=1. Then a lone 75 -> no change. Then E0,F0,75 -> gas_held=0. Also check that 75 alone after reset produces no gas event.
- Bytes E0, then TIMEOUT_CYC idle cycles, then 75 -> FSM is back in IDLE, so 75 is treated as non-extended and no gas event occurs. The same bytes with a gap of TIMEOUT_CYC-2 cycles -> gas press is detected.
- With shift held and gas held, assert reset_status for 1 cycle -> both held flags 0 and no pulses. A following 29 -> new shift_posedge pulse.
- Byte 29 with rst asserted in the same cycle -> no pulse and shift_held=0. Also send F0 then 75 (non-matching, non-extended) -> no output change and FSM back in IDLE.
